lights_out_grid: RTL

- Parametrised ROWS x COLS Lights Out game core; successor to the fixed 3x3 board with one-hot buttons.
- Adds an indexed press handshake, LFSR-driven scramble that always yields a solvable board, direct board load, win detection and a saturating move counter.
- Sits between the pad/button front end and the LED matrix driver; `field` drives the lamps directly.

---
 rtl/lights_out_grid_if.sv | 33 +++
 rtl/lights_out_grid.sv | 138 +++++++++++++
 2 files changed

// File: rtl/lights_out_grid_if.sv
// Front-end <-> game-core bundle: request strobes in, board/status out.
interface lights_out_grid_if #(
  parameter int ROWS   = 3,
  parameter int COLS   = 3,
  parameter int MOVE_W = 8
);
  localparam int N_CELLS = ROWS * COLS;
  localparam int IDX_W   = $clog2(N_CELLS);

  logic                new_game;
  logic                seed_valid;
  logic [15:0]         seed;
  logic                load_valid;
  logic [N_CELLS-1:0]  load_field;
  logic                press_valid;
  logic [IDX_W-1:0]    press_idx;
  logic                press_ready;
  logic                bad_press;
  logic [N_CELLS-1:0]  field;
  logic [MOVE_W-1:0]   move_count;
  logic                solved;
  logic                busy;

  modport master (
    output new_game, seed_valid, seed, load_valid, load_field, press_valid, press_idx,
    input  press_ready, bad_press, field, move_count, solved, busy
  );

  modport slave (
    input  new_game, seed_valid, seed, load_valid, load_field, press_valid, press_idx,
    output press_ready, bad_press, field, move_count, solved, busy
  );
endinterface

// File: rtl/lights_out_grid.sv
// Parametrised Lights Out core: indexed presses, LFSR scramble, board load,
// win detection and a saturating move counter.
module lights_out_grid #(
  parameter int          ROWS           = 3,
  parameter int          COLS           = 3,
  parameter int          MOVE_W         = 8,
  parameter int          SCRAMBLE_MOVES = 16,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  lights_out_grid_if.slave  bus
);
  localparam int unsigned N_CELLS   = ROWS * COLS;
  localparam int unsigned COLS_U    = COLS;
  localparam int          IDX_W     = $clog2(N_CELLS);
  localparam int          CNT_W     = $clog2(SCRAMBLE_MOVES + 1);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {IDLE, SCRAMBLE, PLAY, SOLVED} state_t;

  state_t               state_q,  state_d;
  logic [N_CELLS-1:0]   field_q,  field_d;
  logic [MOVE_W-1:0]    move_q,   move_d;
  logic [CNT_W-1:0]     cnt_q,    cnt_d;
  logic [15:0]          lfsr_q,   lfsr_d;
  logic                 bad_q,    bad_d;
  logic                 solved_q, solved_d;
  logic                 busy_q,   busy_d;
  logic                 ready_q,  ready_d;

  logic [IDX_W-1:0]     scr_k;
  logic [N_CELLS-1:0]   scr_mask;
  logic [N_CELLS-1:0]   press_mask;

  // Cell plus existing orthogonal neighbours; the loop keeps every
  // row/column split a constant so no divider is built.
  function automatic logic [N_CELLS-1:0] toggle_mask(input logic [IDX_W-1:0] idx);
    logic [N_CELLS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < N_CELLS; i++) begin
      if (32'(idx) == i) begin
        m = m | (N_CELLS'(1) << i);
        if (i >= COLS_U)             m = m | (N_CELLS'(1) << (i - COLS_U));
        if (i + COLS_U < N_CELLS)    m = m | (N_CELLS'(1) << (i + COLS_U));
        if (i % COLS_U != 0)         m = m | (N_CELLS'(1) << (i - 1));
        if (i % COLS_U != COLS_U - 1) m = m | (N_CELLS'(1) << (i + 1));
      end
    end
    return m;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0000);
  endfunction

  // Next-state logic: game FSM, board, counters and LFSR.
  always_comb begin
    state_d    = state_q;
    field_d    = field_q;
    move_d     = move_q;
    cnt_d      = cnt_q;
    bad_d      = 1'b0;
    lfsr_d     = bus.seed_valid ? ((bus.seed == 16'h0000) ? 16'h0001 : bus.seed)
                                : lfsr_step(lfsr_q);
    scr_k      = lfsr_q[IDX_W-1:0];
    scr_mask   = toggle_mask(scr_k);
    press_mask = toggle_mask(bus.press_idx);

    case (state_q)
      SCRAMBLE: begin
        // Counter holds at zero while the board is dark, so scrambling keeps
        // landing valid presses until something is lit.
        if (32'(scr_k) < N_CELLS) begin
          field_d = field_q ^ scr_mask;
          cnt_d   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
          if (cnt_d == '0 && field_d != '0) state_d = PLAY;
        end
      end
      default: begin
        if (bus.new_game) begin
          field_d = '0;
          move_d  = '0;
          cnt_d   = CNT_W'(SCRAMBLE_MOVES);
          state_d = SCRAMBLE;
        end else if (bus.load_valid) begin
          field_d = bus.load_field;
          move_d  = '0;
          state_d = (bus.load_field == '0) ? SOLVED : PLAY;
        end else if (state_q == PLAY && bus.press_valid) begin
          if (32'(bus.press_idx) < N_CELLS) begin
            field_d = field_q ^ press_mask;
            move_d  = (move_q == '1) ? move_q : move_q + MOVE_W'(1);
            if (field_d == '0) state_d = SOLVED;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
    endcase

    solved_d = (state_d == SOLVED);
    busy_d   = (state_d == SCRAMBLE);
    ready_d  = (state_d == PLAY);
  end

  // State and registered outputs; reset overrides every other request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      field_q  <= '0;
      move_q   <= '0;
      cnt_q    <= '0;
      lfsr_q   <= SEED;
      bad_q    <= 1'b0;
      solved_q <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      field_q  <= field_d;
      move_q   <= move_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      bad_q    <= bad_d;
      solved_q <= solved_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  assign bus.field       = field_q;
  assign bus.move_count  = move_q;
  assign bus.solved      = solved_q;
  assign bus.busy        = busy_q;
  assign bus.press_ready = ready_q;
  assign bus.bad_press   = bad_q;
endmodule
